// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port synchronous RAM between the cpu fetch port
// and the program loader; one access at a time, each answered with a one-cycle ack.
module ram_arbiter #(
   parameter int DWIDTH  = 16,
   parameter int AWIDTH  = 8,
   parameter int RAM_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic [DWIDTH-1:0] cpu_addr,
   output logic              cpu_ack,
   output logic [DWIDTH-1:0] cpu_rdata,
   output logic              cpu_ovf,
   input  logic              ld_req,
   input  logic              ld_we,
   input  logic [AWIDTH-1:0] ld_addr,
   input  logic [DWIDTH-1:0] ld_wdata,
   input  logic              ld_prio,
   output logic              ld_ack,
   output logic [DWIDTH-1:0] ld_rdata,
   output logic              ram_cs,
   output logic              ram_we,
   output logic [AWIDTH-1:0] ram_addr,
   output logic [DWIDTH-1:0] ram_wdata,
   input  logic [DWIDTH-1:0] ram_rdata,
   output logic              busy
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   localparam logic [2:0] WAIT_LAST = 3'(RAM_LAT - 1);

   state_t            state;
   logic              cpu_pend;
   logic [AWIDTH-1:0] cpu_addr_q;
   logic              ld_mask;
   logic              last_cpu;
   logic              grant_ld;
   logic              is_write;
   logic [2:0]        wait_cnt;

   logic cpu_any, ld_any, pick_ld, cpu_resp;
   logic unused_addr_bits;

   assign unused_addr_bits = ^cpu_addr[DWIDTH-1:AWIDTH];

   // A same-cycle cpu_req counts as pending so an idle arbiter issues on the next cycle.
   assign cpu_any  = cpu_pend | cpu_req;
   assign ld_any   = ld_req & ~ld_mask;
   assign pick_ld  = ld_any & (~cpu_any | ld_prio | last_cpu);
   assign cpu_resp = (state == RESP) & ~grant_ld;
   assign busy     = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cpu_pend   <= 1'b0;
         cpu_addr_q <= '0;
         cpu_ovf    <= 1'b0;
         cpu_ack    <= 1'b0;
         cpu_rdata  <= '0;
         ld_ack     <= 1'b0;
         ld_rdata   <= '0;
         ld_mask    <= 1'b0;
         last_cpu   <= 1'b0;
         grant_ld   <= 1'b0;
         is_write   <= 1'b0;
         wait_cnt   <= '0;
         ram_cs     <= 1'b0;
         ram_we     <= 1'b0;
         ram_addr   <= '0;
         ram_wdata  <= '0;
      end else begin
         ram_cs  <= 1'b0;
         ram_we  <= 1'b0;
         cpu_ack <= 1'b0;
         ld_ack  <= 1'b0;
         ld_mask <= ld_ack;

         // A new strobe in the cpu RESP cycle is accepted: set wins over clear.
         if (cpu_req) begin
            if (cpu_pend && !cpu_resp) begin
               cpu_ovf <= 1'b1;
            end else begin
               cpu_pend   <= 1'b1;
               cpu_addr_q <= cpu_addr[AWIDTH-1:0];
            end
         end else if (cpu_resp) begin
            cpu_pend <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (cpu_any || ld_any) begin
                  state    <= ISSUE;
                  grant_ld <= pick_ld;
                  ram_cs   <= 1'b1;
                  if (pick_ld) begin
                     ram_we    <= ld_we;
                     is_write  <= ld_we;
                     ram_addr  <= ld_addr;
                     ram_wdata <= ld_wdata;
                  end else begin
                     is_write <= 1'b0;
                     ram_addr <= cpu_pend ? cpu_addr_q : cpu_addr[AWIDTH-1:0];
                  end
               end
            end
            ISSUE: begin
               state    <= WAIT;
               wait_cnt <= WAIT_LAST;
            end
            WAIT: begin
               if (wait_cnt == 3'd0) begin
                  state <= RESP;
                  if (grant_ld) begin
                     ld_ack <= 1'b1;
                     if (!is_write) ld_rdata <= ram_rdata;
                  end else begin
                     cpu_ack   <= 1'b1;
                     cpu_rdata <= ram_rdata;
                  end
               end else begin
                  wait_cnt <= wait_cnt - 3'd1;
               end
            end
            RESP: begin
               state    <= IDLE;
               last_cpu <= ~grant_ld;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
